comp_seq_ctrl: RTL and testbench
================================

// Module: comp_seq_ctrl
// PURPOSE
//  Sequencer that compares two WIDTH-bit unsigned operands with one shared
//  4-bit comparator (comp1, outputs less/greater/eq), one nibble per cycle.
//  Runs MSB nibble first; the first unequal nibble decides the result.
//  Sits between a requester (start/done handshake) and the comparator datapath.
// PARAMETERS
//  WIDTH   16   operand width; multiple of 4, >= 4; NIB = WIDTH/4 (localparam)
// PORTS
//  clk      in   1      single clock, rising edge
//  rst      in   1      synchronous, active-high reset
//  start    in   1      request; accepted only when busy==0
//  a_in     in   WIDTH  operand A, sampled on accepted start
//  b_in     in   WIDTH  operand B, sampled on accepted start
//  busy     out  1      high while nibbles are being compared (RUN)
//  done     out  1      one-cycle pulse: less/greater/eq valid from this cycle
//  less     out  1      A < B  (registered, held until next done)
//  greater  out  1      A > B  (registered, held until next done)
//  eq       out  1      A == B (registered, held until next done)
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, less=0, greater=0, eq=0; index and
//    operand registers cleared. rst has priority over start.
//  - States: IDLE, RUN, DONE.
//    IDLE: start=1 -> capture a_in/b_in, idx=NIB-1, go RUN; else stay.
//    RUN:  comp1 gets nibble idx of captured A/B (bits 4*idx+3:4*idx).
//          unequal nibble -> latch first decision into sticky flag;
//          idx==0 (or early exit, see CONFIGURATION) -> go DONE; else idx--.
//    DONE: done=1 for exactly this cycle; less/greater/eq updated at the
//          RUN->DONE edge, so they are valid in the DONE cycle.
//          start=1 -> capture new operands, go RUN (back-to-back); else IDLE.
//  - Exactly one of less/greater/eq is 1 after the first done; all 0 before.
//  - Result = first unequal nibble from MSB; no such nibble -> eq=1.
//  - Outputs never change during RUN; they hold until the next done.
//  - start while busy=1 ignored: no capture, no extra done.
//  - Latency: start sampled on edge E0; k nibbles compared (1 per cycle);
//    done high in cycle k+1 after E0. Min k=1, max k=NIB.
//  - Operand inputs may change freely after the accepting edge.
//  - rst mid-RUN: next cycle IDLE, all outputs 0, operation dropped, no done.
// CONFIGURATION
//  COMP_EARLY_EXIT_EN defined: RUN -> DONE on the first unequal nibble,
//    so k = (position of first unequal nibble from MSB) + 1; k = NIB when equal.
//  COMP_EARLY_EXIT_EN undefined: always k = NIB (fixed latency NIB+1).
//    The first inequality is still kept sticky, so the result is identical.
// TESTING (WIDTH=16, NIB=4)
//  1 a=16'h1234 b=16'h1234 start 1 cycle -> busy 4 cyc, done cyc 5, eq=1 lt=0 gt=0
//  2 a=16'h8000 b=16'h7FFF -> gt=1; done cyc 2 with _EN, cyc 5 without
//  3 a=16'h1230 b=16'h1231 -> lt=1, done cyc 5 both configs
//  4 start a=16'h0001,b=16'h0002; 2nd start a=16'hFFFF,b=16'h0000 during busy
//    -> single done, lt=1; second request ignored
//  5 rst=1 in 2nd RUN cycle of case 1 -> next cycle busy=0 done=0 all flags 0,
//    no done for 10 cycles
//  6 start held high: a=16'h0010,b=16'h0001 then a=16'h0001,b=16'h0010 in done
//    cycle -> gt=1 at 1st done, lt=1 at 2nd done, no IDLE gap

Source files
------------

// File: rtl/comp_seq_ctrl.sv
// Nibble-serial magnitude comparator: one shared 4-bit comparator, MSB nibble first.
// Optional COMP_EARLY_EXIT_EN: finish on the first unequal nibble instead of after all NIB nibbles.

module comp1 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic       lt_c,
   output logic       gt_c,
   output logic       eq_c
);
   assign lt_c = (a_i < b_i);
   assign gt_c = (a_i > b_i);
   assign eq_c = (a_i == b_i);
endmodule

module comp_seq_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             less,
   output logic             greater,
   output logic             eq
);

   localparam int unsigned NIB  = WIDTH / 4;
   localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

`ifdef COMP_EARLY_EXIT_EN
   localparam logic EARLY_EXIT = 1'b1;
`else
   localparam logic EARLY_EXIT = 1'b0;
`endif

   logic [1:0]      state_q,  state_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic [IDXW-1:0] idx_q,    idx_d;
   logic            dec_q,    dec_d;
   logic            dec_lt_q, dec_lt_d;
   logic            dec_gt_q, dec_gt_d;
   logic            busy_q,   busy_d;
   logic            done_q,   done_d;
   logic            lt_q,     lt_d;
   logic            gt_q,     gt_d;
   logic            eq_q,     eq_d;

   logic [3:0]      nib_a_c;
   logic [3:0]      nib_b_c;
   logic            cmp_lt_c;
   logic            cmp_gt_c;
   logic            cmp_eq_c;
   logic            dec_now_c;
   logic            lt_now_c;
   logic            gt_now_c;
   logic            last_c;

   // Current nibble of the captured operands feeds the shared comparator.
   assign nib_a_c = a_q[{idx_q, 2'b00} +: 4];
   assign nib_b_c = b_q[{idx_q, 2'b00} +: 4];

   comp1 u_comp1 (
      .a_i  (nib_a_c),
      .b_i  (nib_b_c),
      .lt_c (cmp_lt_c),
      .gt_c (cmp_gt_c),
      .eq_c (cmp_eq_c)
   );

   // The first unequal nibble wins; later nibbles cannot override it.
   assign dec_now_c = dec_q | ~cmp_eq_c;
   assign lt_now_c  = dec_q ? dec_lt_q : cmp_lt_c;
   assign gt_now_c  = dec_q ? dec_gt_q : cmp_gt_c;
   assign last_c    = (idx_q == '0) | (EARLY_EXIT & ~cmp_eq_c);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      idx_d    = idx_q;
      dec_d    = dec_q;
      dec_lt_d = dec_lt_q;
      dec_gt_d = dec_gt_q;
      lt_d     = lt_q;
      gt_d     = gt_q;
      eq_d     = eq_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d      = a_in;
               b_d      = b_in;
               idx_d    = IDXW'(NIB - 1);
               dec_d    = 1'b0;
               dec_lt_d = 1'b0;
               dec_gt_d = 1'b0;
               state_d  = S_RUN;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_RUN: begin
            dec_d    = dec_now_c;
            dec_lt_d = lt_now_c;
            dec_gt_d = gt_now_c;
            if (last_c) begin
               lt_d    = dec_now_c & lt_now_c;
               gt_d    = dec_now_c & gt_now_c;
               eq_d    = ~dec_now_c;
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q - IDXW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         idx_q    <= '0;
         dec_q    <= 1'b0;
         dec_lt_q <= 1'b0;
         dec_gt_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         lt_q     <= 1'b0;
         gt_q     <= 1'b0;
         eq_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         idx_q    <= idx_d;
         dec_q    <= dec_d;
         dec_lt_q <= dec_lt_d;
         dec_gt_q <= dec_gt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         lt_q     <= lt_d;
         gt_q     <= gt_d;
         eq_q     <= eq_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign less    = lt_q;
   assign greater = gt_q;
   assign eq      = eq_q;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Bench for comp_seq_ctrl: vector table plus multi-cycle sequences, checked via an expected-result queue.
// Latency expectations follow COMP_EARLY_EXIT_EN when it is defined for the build.

module tb_comp_seq_ctrl;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NIB   = WIDTH / 4;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       flags;   // {less, greater, eq}
   } vec_t;

   typedef struct {
      logic [2:0] flags;
      int         done_cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic             less;
   logic             greater;
   logic             eq;

   exp_t       sb_q[$];
   vec_t       vecs[12];
   int         tests = 0;
   int         fails = 0;
   int         cyc   = 0;
   logic [2:0] held;
   int         busy_lo;
   int         busy_hi;
   int         free_cyc;
   int         d1;

   comp_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a_in    (a_in),
      .b_in    (b_in),
      .busy    (busy),
      .done    (done),
      .less    (less),
      .greater (greater),
      .eq      (eq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int exp_k(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int k;
      k = NIB;
`ifdef COMP_EARLY_EXIT_EN
      begin
         bit found;
         found = 1'b0;
         for (int i = NIB - 1; i >= 0; i--) begin
            if (!found && (a[4*i +: 4] != b[4*i +: 4])) begin
               k     = NIB - i;
               found = 1'b1;
            end
         end
      end
`endif
      return k;
   endfunction

   function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (a < b)      return 3'b100;
      else if (a > b) return 3'b010;
      else            return 3'b001;
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
      end
   endtask

   task automatic check();
      logic exp_done;
      exp_done = (sb_q.size() > 0) && (sb_q[0].done_cyc == cyc);
      chk("busy", int'(busy), int'((cyc >= busy_lo) && (cyc <= busy_hi)));
      chk("done", int'(done), int'(exp_done));
      if (exp_done) begin
         held = sb_q[0].flags;
         void'(sb_q.pop_front());
      end
      while ((sb_q.size() > 0) && (sb_q[0].done_cyc < cyc)) void'(sb_q.pop_front());
      chk("flags_lt_gt_eq", int'({less, greater, eq}), int'(held));
   endtask

   task automatic tick();
      @(negedge clk);
      check();
   endtask

   // Requests are only queued when the model says the DUT is not busy.
   task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [2:0] flags);
      int   k;
      exp_t e;
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      if (cyc >= free_cyc) begin
         k          = exp_k(a, b);
         e.flags    = flags;
         e.done_cyc = cyc + 1 + k;
         sb_q.push_back(e);
         busy_lo    = cyc + 1;
         busy_hi    = cyc + k;
         free_cyc   = cyc + 1 + k;
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      held     = 3'b000;
      busy_lo  = 1;
      busy_hi  = 0;
      free_cyc = 0;
   endtask

   initial begin
      vecs[0]  = '{16'h1234, 16'h1234, 3'b001};
      vecs[1]  = '{16'h8000, 16'h7FFF, 3'b010};
      vecs[2]  = '{16'h1230, 16'h1231, 3'b100};
      vecs[3]  = '{16'h0001, 16'h0002, 3'b100};
      vecs[4]  = '{16'hFFFF, 16'h0000, 3'b010};
      vecs[5]  = '{16'h0000, 16'h0000, 3'b001};
      vecs[6]  = '{16'hFFFF, 16'hFFFF, 3'b001};
      vecs[7]  = '{16'h0F00, 16'h0E00, 3'b010};
      vecs[8]  = '{16'hABCD, 16'hABDD, 3'b100};
      vecs[9]  = '{16'h7000, 16'h8000, 3'b100};
      vecs[10] = '{16'h0010, 16'h0001, 3'b010};
      vecs[11] = '{16'h0001, 16'h0010, 3'b100};

      rst   = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check();
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         drive_start(vecs[i].a, vecs[i].b, vecs[i].flags);
         tick();
         start = 1'b0;
         a_in  = ~a_in;
         b_in  = ~b_in;
         repeat (NIB + 1) tick();
      end

      // A second request while busy must be dropped.
      drive_start(16'h0001, 16'h0002, ref_flags(16'h0001, 16'h0002));
      tick();
      drive_start(16'hFFFF, 16'h0000, ref_flags(16'hFFFF, 16'h0000));
      tick();
      start = 1'b0;
      repeat (NIB + 3) tick();

      // Reset in the second RUN cycle abandons the operation.
      drive_start(16'h1234, 16'h1234, 3'b001);
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      model_reset();
      tick();
      rst = 1'b0;
      repeat (10) tick();

      // Start held high: new operands accepted in the done cycle, no idle gap.
      drive_start(16'h0010, 16'h0001, 3'b010);
      d1 = free_cyc;
      while (cyc < d1) begin
         tick();
         if (cyc == d1) drive_start(16'h0001, 16'h0010, 3'b100);
         else           drive_start(16'h0010, 16'h0001, 3'b010);
      end
      tick();
      start = 1'b0;
      repeat (NIB + 2) tick();

      chk("scoreboard_drained", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
